// File: rtl/adder_seq_ctrl_if.sv
// Bus between the sequencing controller and the shared WIDTH-bit ripple-carry add/sub datapath.
interface adder_seq_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_sub;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    modport master (
        output add_a, add_b, add_sub,
        input  add_sum, add_cout
    );

    modport slave (
        input  add_a, add_b, add_sub,
        output add_sum, add_cout
    );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Sequencing controller for the lab-board add/sub datapath: operand capture, add/sub/clear, chaining.
// Define ADDER_SEQ_MUL_EN to build multiply-by-repeated-addition (op=10); otherwise op=10 acts as add.
module adder_seq_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] sw,
    adder_seq_ctrl_if.master bus,
    output logic [WIDTH-1:0] acc,
    output logic             ovf,
    output logic             busy,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_B = 3'd2,
        EXEC  = 3'd3,
        MUL   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           cur, nxt;
    logic             enter_q;
    logic             enter_rise;
    logic [WIDTH-1:0] opa, opa_d;
    logic [WIDTH-1:0] opb, opb_d;
    logic [1:0]       opr, opr_d;
    logic [WIDTH-1:0] acc_d;
    logic             ovf_d;
`ifdef ADDER_SEQ_MUL_EN
    logic [WIDTH-1:0] cnt, cnt_d;
`endif

    assign enter_rise = enter & ~enter_q;
    assign state      = cur;
    assign busy       = (cur == EXEC) || (cur == MUL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= IDLE;
            enter_q <= 1'b0;
            opa     <= '0;
            opb     <= '0;
            opr     <= '0;
            acc     <= '0;
            ovf     <= 1'b0;
`ifdef ADDER_SEQ_MUL_EN
            cnt     <= '0;
`endif
        end else begin
            cur     <= nxt;
            enter_q <= enter;
            opa     <= opa_d;
            opb     <= opb_d;
            opr     <= opr_d;
            acc     <= acc_d;
            ovf     <= ovf_d;
`ifdef ADDER_SEQ_MUL_EN
            cnt     <= cnt_d;
`endif
        end
    end

    // In MUL the adder accumulates opa onto acc; otherwise it sees the captured operands.
    always_comb begin
        bus.add_a   = opa;
        bus.add_b   = opb;
        bus.add_sub = opr[0];
`ifdef ADDER_SEQ_MUL_EN
        if (cur == MUL) begin
            bus.add_a   = acc;
            bus.add_b   = opa;
            bus.add_sub = 1'b0;
        end
`endif
    end

    always_comb begin
        nxt   = cur;
        opa_d = opa;
        opb_d = opb;
        opr_d = opr;
        acc_d = acc;
        ovf_d = ovf;
`ifdef ADDER_SEQ_MUL_EN
        cnt_d = cnt;
`endif
        case (cur)
            IDLE: begin
                if (enter_rise) begin
                    opa_d = sw;
                    nxt   = GET_B;
                end
            end
            GET_B: begin
                if (enter_rise) begin
                    opb_d = sw;
                    opr_d = op;
                    if (op == 2'b11) begin
                        acc_d = '0;
                        ovf_d = 1'b0;
                        nxt   = IDLE;
                    end else begin
                        nxt = EXEC;
                    end
                end
            end
            EXEC: begin
                case (opr)
                    2'b01: begin
                        acc_d = bus.add_sum;
                        ovf_d = ~bus.add_cout;
                        nxt   = DONE;
                    end
`ifdef ADDER_SEQ_MUL_EN
                    2'b10: begin
                        acc_d = '0;
                        ovf_d = 1'b0;
                        cnt_d = opb;
                        nxt   = (opb == '0) ? DONE : MUL;
                    end
`endif
                    default: begin
                        acc_d = bus.add_sum;
                        ovf_d = bus.add_cout;
                        nxt   = DONE;
                    end
                endcase
            end
`ifdef ADDER_SEQ_MUL_EN
            MUL: begin
                acc_d = bus.add_sum;
                ovf_d = ovf | bus.add_cout;
                cnt_d = cnt - WIDTH'(1);
                if (cnt == WIDTH'(1)) begin
                    nxt = DONE;
                end
            end
`endif
            DONE: begin
                if (enter_rise) begin
                    if (op == 2'b11) begin
                        acc_d = '0;
                        ovf_d = 1'b0;
                        nxt   = IDLE;
                    end else begin
                        opa_d = acc;
                        opb_d = sw;
                        opr_d = op;
                        nxt   = EXEC;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Randomized self-checking bench for adder_seq_ctrl against an arithmetic reference model.
module tb_adder_seq_ctrl;

    localparam int unsigned W = 4;
    localparam int M = 1 << W;

    logic         clk;
    logic         reset;
    logic         enter;
    logic [1:0]   op;
    logic [W-1:0] sw;
    logic [W-1:0] acc;
    logic         ovf;
    logic         busy;
    logic [2:0]   state;

    int n_checks;
    int n_errors;
    int m_acc;

    adder_seq_ctrl_if #(.WIDTH(W)) bus ();

    // Behavioural stand-in for the board's ripple-carry adder.
    logic [W:0] full_sum;
    assign full_sum     = {1'b0, bus.add_a} + {1'b0, (bus.add_sub ? ~bus.add_b : bus.add_b)}
                        + {{W{1'b0}}, bus.add_sub};
    assign bus.add_sum  = full_sum[W-1:0];
    assign bus.add_cout = full_sum[W];

    adder_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .enter (enter),
        .op    (op),
        .sw    (sw),
        .bus   (bus),
        .acc   (acc),
        .ovf   (ovf),
        .busy  (busy),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int a, input int b, input int o,
                                  output int r, output int v, output int cyc);
        cyc = 1;
`ifdef ADDER_SEQ_MUL_EN
        if (o == 2) begin
            r   = (a * b) % M;
            v   = (a * b >= M) ? 1 : 0;
            cyc = b + 1;
        end else
`endif
        if (o == 1) begin
            r = (a - b + M) % M;
            v = (a < b) ? 1 : 0;
        end else begin
            r = (a + b) % M;
            v = (a + b >= M) ? 1 : 0;
        end
    endfunction

    // One-cycle enter pulse; returns at the negedge right after the capturing posedge.
    task automatic press(input int v, input int o);
        @(negedge clk);
        sw    = W'(v);
        op    = 2'(o);
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
    endtask

    task automatic finish_op(input int a, input int b, input int o, input bit inject);
        int r, v, cyc, i;
        model(a, b, o, r, v, cyc);
        i = 0;
        while (busy === 1'b1 && i < 64) begin
            if (i == 0) begin
                check("exec_state", state, 3);
                check("exec_add_sub", bus.add_sub, (o == 1) ? 1 : 0);
            end
`ifdef ADDER_SEQ_MUL_EN
            if (o == 2 && i >= 1) begin
                check("mul_acc_seq", acc, ((i - 1) * a) % M);
                check("mul_add_sub", bus.add_sub, 0);
            end
`endif
            if (inject && i == 2) begin
                sw    = W'($urandom);
                op    = 2'd3;
                enter = 1'b1;
            end else begin
                enter = 1'b0;
            end
            i++;
            @(negedge clk);
        end
        enter = 1'b0;
        check("busy_cycles", i, cyc);
        check("result_acc", acc, r);
        check("result_ovf", ovf, v);
        check("done_state", state, 5);
        check("done_busy", busy, 0);
        m_acc = r;
    endtask

    task automatic do_first(input int a, input int b, input int o, input bit inject);
        press(a, 0);
        check("getb_state", state, 2);
        press(b, o);
        finish_op(a, b, o, inject);
    endtask

    task automatic do_chain(input int b, input int o);
        int a;
        a = m_acc;
        press(b, o);
        finish_op(a, b, o, 1'b0);
    endtask

    task automatic do_clear();
        press(int'($urandom_range(M - 1)), 3);
        check("clear_state", state, 0);
        check("clear_acc", acc, 0);
        check("clear_ovf", ovf, 0);
        m_acc = 0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_acc    = 0;
        reset    = 1'b1;
        enter    = 1'b0;
        op       = 2'd0;
        sw       = '0;
        repeat (2) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_acc", acc, 0);
        check("rst_ovf", ovf, 0);
        check("rst_busy", busy, 0);
        check("rst_add_a", bus.add_a, 0);
        check("rst_add_b", bus.add_b, 0);
        check("rst_add_sub", bus.add_sub, 0);
        reset = 1'b0;

        do_first(9, 8, 0, 1'b0);
        do_clear();
        do_first(3, 5, 1, 1'b0);
        do_clear();
`ifdef ADDER_SEQ_MUL_EN
        do_first(5, 3, 2, 1'b0);
        do_clear();
        do_first(6, 3, 2, 1'b0);
        do_clear();
        do_first(7, 0, 2, 1'b0);
        do_clear();
        do_first(5, 6, 2, 1'b1);
        do_clear();
`endif
        do_first(7, 2, 0, 1'b0);
        do_chain(4, 1);
        do_clear();

        // A held enter level must register as a single edge.
        @(negedge clk);
        sw    = W'(6);
        enter = 1'b1;
        repeat (10) @(negedge clk);
        enter = 1'b0;
        check("held_enter_state", state, 2);
        press(5, 0);
        finish_op(6, 5, 0, 1'b0);

        // Clear from GET_B.
        do_clear();
        press(3, 0);
        press(4, 3);
        check("getb_clear_state", state, 0);
        check("getb_clear_acc", acc, 0);

        // Asynchronous reset in the middle of an operation.
        do_first(9, 8, 0, 1'b0);
`ifdef ADDER_SEQ_MUL_EN
        press(7, 2);
        repeat (3) @(negedge clk);
`else
        press(7, 0);
`endif
        check("pre_rst_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_state", state, 0);
        check("async_rst_acc", acc, 0);
        check("async_rst_ovf", ovf, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        m_acc = 0;

        for (int k = 0; k < 40; k++) begin
            int nchain;
            do_first(int'($urandom_range(M - 1)), int'($urandom_range(M - 1)),
                     int'($urandom_range(2)), 1'b0);
            nchain = int'($urandom_range(2));
            for (int c = 0; c < nchain; c++) begin
                do_chain(int'($urandom_range(M - 1)), int'($urandom_range(2)));
            end
            do_clear();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
